// File: rtl/split_feeder.sv
// Split-checker feeder: gathers a flat assignment word by word, requests a check,
// then offers the latched result and counts passing assignments.
module split_feeder #(
  parameter int unsigned TOTAL_W = 551,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  output logic [TOTAL_W-1:0] asgn,
  output logic               asgn_valid,
  input  logic               chk_done,
  input  logic               chk_x,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_x,
  output logic [CNT_W-1:0]   pass_cnt
);

  localparam int unsigned NWORDS = (TOTAL_W + WORD_W - 1) / WORD_W;
  localparam int unsigned PadW   = NWORDS * WORD_W;
  localparam int unsigned BeatW  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {StLoad, StCheck, StReport} state_e;

  state_e             state_q, state_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [TOTAL_W-1:0] asgn_q, asgn_d;
  logic [PadW-1:0]    asgn_pad;
  logic               res_x_q, res_x_d;
  logic [CNT_W-1:0]   pass_q, pass_d;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    res_x_d  = res_x_q;
    pass_d   = pass_q;
    // Padded view lets the last word be written whole; its excess bits are dropped below.
    asgn_pad = PadW'(asgn_q);
    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          asgn_pad[beat_q*WORD_W +: WORD_W] = in_data;
          if (beat_q == BeatW'(NWORDS - 1)) begin
            beat_d  = '0;
            state_d = StCheck;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StCheck: begin
        if (chk_done) begin
          res_x_d = chk_x;
          state_d = StReport;
        end
      end
      StReport: begin
        if (res_ready) begin
          state_d = StLoad;
          if (res_x_q && (pass_q != '1)) pass_d = pass_q + 1'b1;
        end
      end
      default: state_d = StLoad;
    endcase
    asgn_d = asgn_pad[TOTAL_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoad;
      beat_q  <= '0;
      asgn_q  <= '0;
      res_x_q <= 1'b0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      asgn_q  <= asgn_d;
      res_x_q <= res_x_d;
      pass_q  <= pass_d;
    end
  end

  assign in_ready   = (state_q == StLoad);
  assign asgn_valid = (state_q == StCheck);
  assign res_valid  = (state_q == StReport);
  assign asgn       = asgn_q;
  assign res_x      = res_x_q;
  assign pass_cnt   = pass_q;

endmodule

// File: doc/split_feeder.md
SPLIT_FEEDER -- requirements
Module: split_feeder

Interface
REQ-001 SHALL have parameter TOTAL_W, default 551, meaning flat assignment width (all split variables concatenated, var_0 at LSB).
REQ-002 SHALL have parameter WORD_W, default 32, meaning input word width; NWORDS = ceil(TOTAL_W/WORD_W), 18 at defaults.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, meaning an input word is offered.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts the offered word.
REQ-007 SHALL have port in_data, input, WORD_W, the assignment word.
REQ-008 SHALL have port asgn, output, TOTAL_W, the packed assignment driven to the split checker.
REQ-009 SHALL have port asgn_valid, output, 1, meaning asgn is stable and a check is requested.
REQ-010 SHALL have port chk_done, input, 1, meaning the checker's result is valid this cycle.
REQ-011 SHALL have port chk_x, input, 1, the checker result (1 = assignment satisfies the split).
REQ-012 SHALL have port res_valid, output, 1, meaning a result is offered.
REQ-013 SHALL have port res_ready, input, 1, meaning the consumer accepts the result.
REQ-014 SHALL have port res_x, output, 1, the latched check result.
REQ-015 SHALL have port pass_cnt, output, 16, a count of accepted results with res_x = 1.

Function
REQ-016 SHALL implement states LOAD, CHECK, REPORT; reset state LOAD.
REQ-017 In LOAD, in_ready SHALL be 1, and a word SHALL be accepted on a cycle with in_valid and in_ready both 1.
REQ-018 Accepted word k (0-based) SHALL be written to asgn bits [k*WORD_W +: WORD_W]; bits at or above TOTAL_W SHALL be discarded.
REQ-019 The beat counter SHALL increment per accepted word; on acceptance of word NWORDS-1, the counter SHALL clear and the state SHALL move to CHECK on the next cycle.
REQ-020 In CHECK, asgn_valid SHALL be 1, in_ready SHALL be 0, and asgn SHALL remain unchanged.
REQ-021 In CHECK, chk_done = 1 SHALL latch chk_x into res_x and move to REPORT; chk_done in any other state SHALL be ignored.
REQ-022 Minimum latency from the last word accepted to res_valid = 1 SHALL be 2 cycles (chk_done asserted in the first CHECK cycle).
REQ-023 In REPORT, res_valid SHALL be 1 and asgn_valid SHALL be 0; res_x SHALL hold until the handshake completes.
REQ-024 A cycle in REPORT with res_ready = 1 SHALL complete the handshake, return the state to LOAD, and increment pass_cnt if res_x = 1.
REQ-025 pass_cnt SHALL saturate at 0xFFFF.
REQ-026 res_ready = 1 outside REPORT SHALL have no effect.
REQ-027 asgn SHALL retain its previous contents in LOAD until each word is overwritten; no clearing between assignments.
REQ-028 in_ready and res_valid SHALL be registered state decodes with no combinational path from in_valid or res_ready.

Reset
REQ-029 While rst_n = 0, the state SHALL be LOAD and the beat counter SHALL be 0.
REQ-030 Reset values SHALL be: asgn = 0, asgn_valid = 0, res_valid = 0, res_x = 0, pass_cnt = 0, in_ready = 1 on the first cycle after release.
REQ-031 Reset asserted mid-load or mid-check SHALL abandon the partial assignment; the next accepted word SHALL be treated as word 0.

Verification
REQ-032 Scenario 1: 18 words 0x00000001..0x00000012 with no gaps, chk_done = 1 and chk_x = 1 in the first CHECK cycle, res_ready = 1. Required: asgn[31:0] = 1; asgn[550:544] = 0x12 with the upper bits of word 17 dropped; res_valid 2 cycles after the last word; res_x = 1; pass_cnt = 1.
REQ-033 Scenario 2: in_valid toggling 1/0 each cycle. Required: 18 accepts over 35 cycles; asgn identical to scenario 1 for identical data.
REQ-034 Scenario 3: chk_done delayed 5 cycles, chk_x = 0, res_ready held 0 for 3 cycles. Required: asgn_valid = 1 for 6 cycles; in_ready = 0 throughout; res_valid = 1 for 4 cycles; pass_cnt unchanged.
REQ-035 Scenario 4: rst_n pulsed low after word 9, then 18 new words. Required: all outputs at reset values during the pulse; the new word 0 lands in asgn[31:0].
REQ-036 Scenario 5: pass_cnt preloaded via 65535 passing results, then one more pass. Required: pass_cnt = 0xFFFF.
REQ-037 Scenario 6: chk_done = 1 pulsed during LOAD and during REPORT. Required: no state change; res_x unchanged.
